// File: rtl/health_pkg.sv
// Shared health-bar types and geometry defaults used by the tracker and the HUD.
package health_pkg;

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DYING,
        DEAD
    } health_state_t;

    localparam int HP_W       = 7;
    localparam int CNT_W      = 7;
    localparam int DEF_BAR_X0 = 2;
    localparam int DEF_HP_MAX = 62;

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronizes a frame-rate strobe into Clk and emits a one-cycle tick per rise.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    // sync[1:0] is the 2-flop synchronizer, sync[2] holds the previous level
    logic [2:0] sync;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync       <= '0;
            frame_tick <= 1'b0;
        end else begin
            sync       <= {sync[1:0], frame_clk};
            frame_tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/health_tracker.sv
// HUD health tracker: true HP target, frame-animated bar value, and
// hit / regeneration / death sequencing.
module health_tracker
    import health_pkg::*;
#(
    parameter int BAR_X0        = DEF_BAR_X0,
    parameter int HP_MAX        = DEF_HP_MAX,
    parameter int INVULN_FRAMES = 30,
    parameter int REGEN_FRAMES  = 60,
    parameter int DEATH_FRAMES  = 90
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    input  logic            dmg_valid,
    input  logic [HP_W-1:0] dmg_amount,
    output logic            dmg_ready,
    input  logic            heal_valid,
    input  logic [HP_W-1:0] heal_amount,
    input  logic            respawn,
    output logic [HP_W-1:0] blood,
    output logic [HP_W-1:0] hp,
    output logic            invulnerable,
    output logic            dead
);

    localparam logic [HP_W-1:0]  HP_FULL    = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  BAR_OFF    = HP_W'(BAR_X0);
    localparam logic [HP_W-1:0]  HP_ONE     = HP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] INV_LOAD   = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] DIE_LOAD   = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0] REGEN_LAST = CNT_W'(REGEN_FRAMES - 1);

    health_state_t    state;
    health_state_t    state_nxt;
    logic             frame_tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] regen_cnt;
    logic             hit;
    logic             heal_ok;
    logic             regen_inc;
    logic signed [8:0] net;
    logic [HP_W-1:0]  hp_sum;
    logic [HP_W-1:0]  target;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // Damage taken while invulnerable is accepted but has no effect
    assign hit       = dmg_valid && state == ALIVE;
    assign heal_ok   = heal_valid && (state == ALIVE || state == INVULN);
    assign regen_inc = frame_tick && state == ALIVE && !hit &&
                       hp < HP_FULL && regen_cnt == REGEN_LAST;
    assign target    = hp + BAR_OFF;

    // Heal, damage and regen combine into one signed delta, clamped once
    always_comb begin
        net = $signed({2'b00, hp});
        if (heal_ok)
            net = net + $signed({2'b00, heal_amount});
        if (hit)
            net = net - $signed({2'b00, dmg_amount});
        if (regen_inc)
            net = net + 9'sd1;
        if (net < 9'sd0)
            hp_sum = '0;
        else if (net > $signed({2'b00, HP_FULL}))
            hp_sum = HP_FULL;
        else
            hp_sum = net[HP_W-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= ALIVE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ALIVE:
                if (hit)
                    state_nxt = (hp_sum == '0) ? DYING : INVULN;
            INVULN:
                if (frame_tick && cnt == CNT_ONE)
                    state_nxt = ALIVE;
            DYING:
                if (frame_tick && cnt == CNT_ONE)
                    state_nxt = DEAD;
            DEAD:
                if (respawn)
                    state_nxt = ALIVE;
        endcase
    end

    always_comb begin
        dmg_ready    = 1'b0;
        invulnerable = 1'b0;
        dead         = 1'b0;
        unique case (state)
            ALIVE:  dmg_ready = 1'b1;
            INVULN: begin
                dmg_ready    = 1'b1;
                invulnerable = 1'b1;
            end
            DYING:  dmg_ready = 1'b0;
            DEAD:   dead = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (state == ALIVE && state_nxt == INVULN) begin
            cnt <= INV_LOAD;
        end else if (state == ALIVE && state_nxt == DYING) begin
            cnt <= DIE_LOAD;
        end else if (frame_tick && cnt != '0 &&
                     (state == INVULN || state == DYING)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            regen_cnt <= '0;
        else if (state != ALIVE || hit || hp == HP_FULL)
            regen_cnt <= '0;
        else if (frame_tick)
            regen_cnt <= regen_inc ? '0 : regen_cnt + CNT_ONE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hp <= HP_FULL;
        end else if (state == DEAD) begin
            if (respawn)
                hp <= HP_FULL;
        end else begin
            hp <= hp_sum;
        end
    end

    // Bar only moves on frame ticks so the renderer sees a stable frame
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blood <= BAR_OFF + HP_FULL;
        end else if (frame_tick) begin
            if (blood < target)
                blood <= blood + HP_ONE;
            else if (blood > target)
                blood <= blood - HP_ONE;
        end
    end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: vector table plus multi-frame sequences.
module tb_health_tracker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       dmg_valid = 1'b0;
    logic [6:0] dmg_amount = '0;
    logic       dmg_ready;
    logic       heal_valid = 1'b0;
    logic [6:0] heal_amount = '0;
    logic       respawn = 1'b0;
    logic [6:0] blood;
    logic [6:0] hp;
    logic       invulnerable;
    logic       dead;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       dv;
        logic [6:0] da;
        logic       hv;
        logic [6:0] ha;
        logic       rs;
        int         fr;
        int         hp;
        logic       inv;
        logic       dead;
        logic       rdy;
    } vec_t;

    vec_t tbl[19];

    health_tracker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .dmg_valid    (dmg_valid),
        .dmg_amount   (dmg_amount),
        .dmg_ready    (dmg_ready),
        .heal_valid   (heal_valid),
        .heal_amount  (heal_amount),
        .respawn      (respawn),
        .blood        (blood),
        .hp           (hp),
        .invulnerable (invulnerable),
        .dead         (dead)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    task automatic pulse(input logic dv, input logic [6:0] da,
                         input logic hv, input logic [6:0] ha,
                         input logic rs);
        dmg_valid   = dv;
        dmg_amount  = da;
        heal_valid  = hv;
        heal_amount = ha;
        respawn     = rs;
        @(negedge Clk);
        dmg_valid   = 1'b0;
        dmg_amount  = '0;
        heal_valid  = 1'b0;
        heal_amount = '0;
        respawn     = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 7'd0,   1'b1, 7'd23, 1'b0, 0,  60, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 7'd0,   1'b1, 7'd10, 1'b0, 0,  62, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 7'd8,   1'b0, 7'd0,  1'b0, 0,  62, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 30, 62, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 7'd32,  1'b0, 7'd0,  1'b0, 0,  30, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 30, 30, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 7'd8,   1'b1, 7'd5,  1'b0, 0,  27, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 30, 27, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b0, 0,  27, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 30, 27, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 7'd24,  1'b0, 7'd0,  1'b0, 0,  3,  1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 30, 3,  1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 7'd100, 1'b0, 7'd0,  1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 7'd0,   1'b1, 7'd20, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b1, 0,  0,  1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 89, 0,  1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 1,  0,  1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 7'd10,  1'b0, 7'd0,  1'b0, 0,  0,  1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 7'd0,   1'b1, 7'd10, 1'b0, 0,  0,  1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_blood", blood, 64);
        chk("rst_hp", hp, 62);
        chk("rst_dead", dead, 0);
        chk("rst_inv", invulnerable, 0);
        chk("rst_ready", dmg_ready, 1);

        pulse(1'b1, 7'd20, 1'b0, 7'd0, 1'b0);
        chk("hit_hp", hp, 42);
        chk("hit_inv", invulnerable, 1);
        chk("hit_blood_hold", blood, 64);
        for (int k = 1; k <= 20; k++) begin
            frames(1);
            chk($sformatf("drain_blood_t%0d", k), blood, 64 - k);
        end

        dmg_valid  = 1'b1;
        dmg_amount = 7'd5;
        chk("inv_ready", dmg_ready, 1);
        @(negedge Clk);
        dmg_valid  = 1'b0;
        dmg_amount = '0;
        chk("inv_hp", hp, 42);
        frames(9);
        chk("inv_still", invulnerable, 1);
        frames(1);
        chk("inv_end", invulnerable, 0);
        chk("inv_end_ready", dmg_ready, 1);
        chk("inv_end_blood", blood, 44);
        pulse(1'b1, 7'd5, 1'b0, 7'd0, 1'b0);
        chk("rehit_hp", hp, 37);
        chk("rehit_inv", invulnerable, 1);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].dv || tbl[i].hv || tbl[i].rs)
                pulse(tbl[i].dv, tbl[i].da, tbl[i].hv,
                      tbl[i].ha, tbl[i].rs);
            frames(tbl[i].fr);
            chk($sformatf("v%0d_hp", i), hp, tbl[i].hp);
            chk($sformatf("v%0d_inv", i), invulnerable, tbl[i].inv);
            chk($sformatf("v%0d_dead", i), dead, tbl[i].dead);
            chk($sformatf("v%0d_ready", i), dmg_ready, tbl[i].rdy);
        end

        chk("dead_blood", blood, 2);
        pulse(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        chk("rsp_hp", hp, 62);
        chk("rsp_dead", dead, 0);
        chk("rsp_ready", dmg_ready, 1);
        chk("rsp_blood", blood, 2);
        for (int k = 1; k <= 62; k++) begin
            frames(1);
            chk($sformatf("refill_blood_t%0d", k), blood, 2 + k);
        end

        pulse(1'b1, 7'd52, 1'b0, 7'd0, 1'b0);
        frames(22);
        chk("middrain_hp", hp, 10);
        chk("middrain_blood", blood, 42);
        Reset = 1'b1;
        #1;
        chk("arst_blood", blood, 64);
        chk("arst_hp", hp, 62);
        chk("arst_inv", invulnerable, 0);
        chk("arst_dead", dead, 0);
        chk("arst_ready", dmg_ready, 1);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        pulse(1'b1, 7'd12, 1'b0, 7'd0, 1'b0);
        chk("regen_start_hp", hp, 50);
        frames(30);
        chk("regen_alive", invulnerable, 0);
        frames(59);
        chk("regen_t59", hp, 50);
        frames(1);
        chk("regen_t60", hp, 51);
        frames(60);
        chk("regen_t120", hp, 52);
        frames(59);
        chk("regen2_t59", hp, 52);
        pulse(1'b1, 7'd2, 1'b0, 7'd0, 1'b0);
        chk("regen_hit_hp", hp, 50);
        frames(1);
        chk("regen_no_inc", hp, 50);
        frames(29);
        chk("regen_hit_alive", invulnerable, 0);
        frames(59);
        chk("regen_restart_t59", hp, 50);
        frames(1);
        chk("regen_restart_t60", hp, 51);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Produces the 7-bit `blood` value consumed by the HUD health-bar renderer.
- Accepts damage and heal requests from the game-logic side and maintains a true health target.
- Animates the displayed value toward the target by one step per video frame.
- Handles post-hit invulnerability, slow regeneration, and death/respawn sequencing.

Parameters:
- BAR_X0, 2, pixel column of an empty bar; blood = BAR_X0 + displayed health.
- HP_MAX, 62, full health; BAR_X0+HP_MAX must equal the bar's right edge (64).
- INVULN_FRAMES, 30, frames of hit immunity after accepted damage.
- REGEN_FRAMES, 60, frames between +1 regen ticks while idle.
- DEATH_FRAMES, 90, frames spent in DYING before DEAD.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vertical-sync-rate frame signal; may be asynchronous to Clk.
- dmg_valid  in  1  damage request valid.
- dmg_amount  in  7  damage in HP units.
- dmg_ready  out  1  request accepted this cycle when high with dmg_valid.
- heal_valid  in  1  single-cycle heal pulse.
- heal_amount  in  7  heal in HP units.
- respawn  in  1  single-cycle pulse; restarts from DEAD only.
- blood  out  7  BAR_X0 + displayed HP, to the health-bar renderer.
- hp  out  7  true target HP.
- invulnerable  out  1  high in INVULN.
- dead  out  1  high in DEAD.

Behaviour:
- Reset (async, any time, including mid-drain or mid-DYING):
  - hp=HP_MAX, displayed=HP_MAX, blood=BAR_X0+HP_MAX.
  - state=ALIVE, all frame counters cleared, dead=0, invulnerable=0.
  - dmg_ready reflects state immediately after reset.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then rising-edge detect.
  - frame_tick is a 1-Clk pulse, 3 Clk after the frame_clk rise.
  - All frame counters advance only on frame_tick.
- States: ALIVE, INVULN, DYING, DEAD.
- dmg_ready = 1 in ALIVE and INVULN; 0 in DYING and DEAD.
  - A request accepted in INVULN is consumed and discarded.
- ALIVE, on accepted damage:
  - hp <= max(hp - dmg_amount, 0), saturating.
  - If the result is 0, go to DYING; else go to INVULN with counter=INVULN_FRAMES.
  - The regen counter is cleared.
  - dmg_amount=0 counts as a hit: it still enters INVULN.
- INVULN:
  - Decrement on each frame_tick; return to ALIVE when the counter reaches 0.
- DYING:
  - Count DEATH_FRAMES ticks, then go to DEAD.
- DEAD:
  - dead=1.
  - On respawn: hp=HP_MAX, displayed unchanged (refills via animation), state=ALIVE.
- Heal:
  - Accepted in ALIVE and INVULN only; ignored in DYING and DEAD.
  - hp <= min(hp + heal_amount, HP_MAX). Use 8-bit intermediate arithmetic so no wrap.
- Simultaneous heal and accepted damage in the same cycle:
  - Net = heal - damage, applied once with both saturations.
  - State transition follows the damage rule if damage > 0 and the net result is 0.
- Regeneration:
  - ALIVE only, when hp < HP_MAX.
  - The regen counter counts frame_ticks; at REGEN_FRAMES: hp += 1, counter=0.
  - The counter is held at 0 when hp == HP_MAX.
- Display animation:
  - On each frame_tick, displayed moves 1 toward hp (down on damage, up on heal/regen/respawn).
  - blood updates 1 Clk after frame_tick.
  - blood changes only on frame_tick, never mid-frame, so the renderer sees a stable value for the whole frame.
- DYING exit:
  - If displayed has not reached 0 when DEATH_FRAMES expires, DEAD is still entered on schedule.
  - Draining continues to 0.
- Outputs are registered; hp, dead, and invulnerable update on the Clk edge after the causing event.

Decomposition:
- Package health_pkg holds:
  - typedef enum logic [1:0] health_state_t {ALIVE, INVULN, DYING, DEAD}.
  - localparams HP_W=7 and BAR_X0/HP_MAX defaults, shared with the HUD.
- One sub-module: frame_tick_gen.
  - 2-flop sync + edge detect, async active-high Reset.
  - Reusable by sprite animators.

Test Plan:
- Reset mid-drain:
  - Stimulus: hp=10, displayed=40, assert Reset.
  - Required: blood=64, hp=62, state ALIVE, with no Clk edge required.
- Hit then drain:
  - Stimulus: dmg 20 in ALIVE.
  - Required: hp=42 next Clk, invulnerable=1; blood steps 64, 63, … one per frame_tick; 44 after 20 ticks.
- Invulnerability:
  - Stimulus: second dmg 5 during INVULN.
  - Required: dmg_ready=1, hp stays 42; ALIVE after 30 ticks; a dmg 5 then gives hp=37.
- Saturation/death:
  - Stimulus: hp=3, dmg 100.
  - Required: hp=0, DYING, dmg_ready=0; dead=1 after 90 ticks; blood reaches 2.
  - Then: respawn → hp=62, blood climbs 2 to 64 over 62 ticks.
- Heal clamp and simultaneous:
  - Stimulus: hp=60, heal 10.
  - Required: hp=62.
  - Stimulus: hp=30, same-cycle heal 5 + dmg 8.
  - Required: hp=27, INVULN.
- Regen:
  - Stimulus: hp=50 in ALIVE, no hits for 120 ticks.
  - Required: hp=52.
  - Stimulus: hit at tick 59.
  - Required: regen counter restarts, no +1 at tick 60.
